// File: rtl/config_report_tx.sv
// rtl/config_report_tx.sv - UART transmitter sending temp1..temp4 and lim_um as five parity frames
module config_report_tx #(
    parameter int CLKS_PER_BIT   = 5208,
    parameter int PARIDADE_IMPAR = 0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enviar,
    input  logic [7:0] temp1,
    input  logic [7:0] temp2,
    input  logic [7:0] temp3,
    input  logic [7:0] temp4,
    input  logic [7:0] lim_um,
    output logic       tx,
    output logic       ocupado,
    output logic       pronto_envio
);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {INICIAL, START, DADOS, PARIDADE, STOP, FIM} state_t;

    state_t      state;
    logic [BW-1:0] baud;
    logic [2:0]  bit_idx;
    logic [2:0]  byte_idx;
    logic [7:0]  s_temp1, s_temp2, s_temp3, s_temp4, s_lim_um;
    logic [7:0]  cur_byte;
    logic        parity_bit;
    logic        bit_end;

    always_comb begin
        cur_byte = s_lim_um;
        case (byte_idx)
            3'd0:    cur_byte = s_temp1;
            3'd1:    cur_byte = s_temp2;
            3'd2:    cur_byte = s_temp3;
            3'd3:    cur_byte = s_temp4;
            default: cur_byte = s_lim_um;
        endcase
    end

    assign parity_bit = (PARIDADE_IMPAR != 0) ? ~^cur_byte : ^cur_byte;
    assign bit_end    = (baud == BAUD_LAST);

    // tx always holds the value of the bit currently on the line; each transition
    // loads the next bit so the line changes on the same edge as the state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= INICIAL;
            tx           <= 1'b1;
            ocupado      <= 1'b0;
            pronto_envio <= 1'b0;
            baud         <= '0;
            bit_idx      <= '0;
            byte_idx     <= '0;
            s_temp1      <= '0;
            s_temp2      <= '0;
            s_temp3      <= '0;
            s_temp4      <= '0;
            s_lim_um     <= '0;
        end else begin
            case (state)
                INICIAL: begin
                    tx           <= 1'b1;
                    ocupado      <= 1'b0;
                    pronto_envio <= 1'b0;
                    baud         <= '0;
                    if (enviar) begin
                        s_temp1  <= temp1;
                        s_temp2  <= temp2;
                        s_temp3  <= temp3;
                        s_temp4  <= temp4;
                        s_lim_um <= lim_um;
                        byte_idx <= '0;
                        bit_idx  <= '0;
                        tx       <= 1'b0;
                        ocupado  <= 1'b1;
                        state    <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        baud    <= '0;
                        bit_idx <= '0;
                        tx      <= cur_byte[0];
                        state   <= DADOS;
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                DADOS: begin
                    if (bit_end) begin
                        baud <= '0;
                        if (bit_idx == 3'd7) begin
                            tx    <= parity_bit;
                            state <= PARIDADE;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= cur_byte[bit_idx + 3'd1];
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                PARIDADE: begin
                    if (bit_end) begin
                        baud  <= '0;
                        tx    <= 1'b1;
                        state <= STOP;
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        baud <= '0;
                        if (byte_idx < 3'd4) begin
                            byte_idx <= byte_idx + 3'd1;
                            tx       <= 1'b0;
                            state    <= START;
                        end else begin
                            tx           <= 1'b1;
                            ocupado      <= 1'b0;
                            pronto_envio <= 1'b1;
                            state        <= FIM;
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                FIM: begin
                    tx           <= 1'b1;
                    ocupado      <= 1'b0;
                    pronto_envio <= 1'b0;
                    state        <= INICIAL;
                end
                default: begin
                    tx    <= 1'b1;
                    state <= INICIAL;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_config_report_tx.sv
// tb/tb_config_report_tx.sv - randomized self-checking bench for config_report_tx
module tb_config_report_tx;
    localparam int C    = 4;
    localparam int NCYC = 55 * C;

    logic clock = 1'b0;
    logic reset;
    logic enviar_e, enviar_o;
    logic [7:0] temp1, temp2, temp3, temp4, lim_um;
    logic tx_e, ocupado_e, pronto_e;
    logic tx_o, ocupado_o, pronto_o;
    logic sel_odd;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    config_report_tx #(.CLKS_PER_BIT(C), .PARIDADE_IMPAR(0)) dut_even (
        .clock(clock), .reset(reset), .enviar(enviar_e),
        .temp1(temp1), .temp2(temp2), .temp3(temp3), .temp4(temp4), .lim_um(lim_um),
        .tx(tx_e), .ocupado(ocupado_e), .pronto_envio(pronto_e)
    );

    config_report_tx #(.CLKS_PER_BIT(C), .PARIDADE_IMPAR(1)) dut_odd (
        .clock(clock), .reset(reset), .enviar(enviar_o),
        .temp1(temp1), .temp2(temp2), .temp3(temp3), .temp4(temp4), .lim_um(lim_um),
        .tx(tx_o), .ocupado(ocupado_o), .pronto_envio(pronto_o)
    );

    wire tx_s      = sel_odd ? tx_o      : tx_e;
    wire ocupado_s = sel_odd ? ocupado_o : ocupado_e;
    wire pronto_s  = sel_odd ? pronto_o  : pronto_e;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference parity from a population count: even mode makes the total number of ones even.
    function automatic logic ref_parity(input logic [7:0] b, input bit odd);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        return odd ? ((ones % 2) == 0) : ((ones % 2) == 1);
    endfunction

    task automatic set_enviar(input logic v);
        if (sel_odd) enviar_o = v; else enviar_e = v;
    endtask

    task automatic load_inputs(input logic [7:0] b [5]);
        temp1 = b[0]; temp2 = b[1]; temp3 = b[2]; temp4 = b[3]; lim_um = b[4];
    endtask

    // mode 0: plain, 1: inputs overwritten after snapshot, 2: extra enviar during byte 2
    task automatic run_transfer(input string name, input bit odd, input logic [7:0] b [5], input int mode);
        logic cap [NCYC];
        int   pulses;
        int   idle_bad;
        int   base;
        int   unstable;
        logic [7:0] got_byte;
        sel_odd = odd;
        @(negedge clock);
        load_inputs(b);
        set_enviar(1'b1);
        @(posedge clock); #1;
        set_enviar(1'b0);
        cap[0] = tx_s;
        check({name, " ocupado_at_start"}, ocupado_s, 1'b1);
        pulses = int'(pronto_s);
        for (int n = 1; n < NCYC; n++) begin
            @(posedge clock); #1;
            cap[n] = tx_s;
            if (pronto_s) pulses++;
            if (mode == 1 && n == 1) begin
                temp1 = 8'hFF; temp2 = 8'hFF; temp3 = 8'hFF; temp4 = 8'hFF; lim_um = 8'hFF;
            end
            if (mode == 2 && n == 100) set_enviar(1'b1);
            if (mode == 2 && n == 101) set_enviar(1'b0);
        end
        check({name, " early_pronto"}, pulses, 0);
        @(posedge clock); #1;
        check({name, " pronto_at_220"}, pronto_s, 1'b1);
        check({name, " ocupado_end"}, ocupado_s, 1'b0);
        check({name, " tx_end"}, tx_s, 1'b1);
        pulses   = 0;
        idle_bad = 0;
        for (int n = 0; n < 3 * 11 * C; n++) begin
            @(posedge clock); #1;
            if (pronto_s) pulses++;
            if (tx_s !== 1'b1) idle_bad++;
        end
        check({name, " pronto_once"}, pulses, 0);
        check({name, " idle_after"}, idle_bad, 0);
        for (int f = 0; f < 5; f++) begin
            base     = f * 11 * C;
            unstable = 0;
            for (int k = 0; k < 11; k++)
                for (int j = 0; j < C; j++)
                    if (cap[base + k * C + j] !== cap[base + k * C + C / 2]) unstable++;
            for (int k = 0; k < 8; k++) got_byte[k] = cap[base + (k + 1) * C + C / 2];
            check($sformatf("%s f%0d start", name, f), cap[base + C / 2], 1'b0);
            check($sformatf("%s f%0d byte", name, f), got_byte, b[f]);
            check($sformatf("%s f%0d parity", name, f), cap[base + 9 * C + C / 2], ref_parity(b[f], odd));
            check($sformatf("%s f%0d stop", name, f), cap[base + 10 * C + C / 2], 1'b1);
            check($sformatf("%s f%0d bit_timing", name, f), unstable, 0);
        end
    endtask

    logic [7:0] bytes_a [5];
    logic [7:0] bytes_b [5];
    logic [7:0] rb [5];
    int hi_cnt;
    int pulses;

    initial begin
        bytes_a = '{8'h19, 8'h1E, 8'h23, 8'h28, 8'h3C};
        bytes_b = '{8'h00, 8'hFF, 8'h01, 8'h80, 8'h7F};
        sel_odd  = 1'b0;
        reset    = 1'b1;
        enviar_e = 1'b0;
        enviar_o = 1'b0;
        load_inputs(bytes_a);
        repeat (3) @(posedge clock);
        @(negedge clock); reset = 1'b0;
        repeat (5) @(posedge clock);

        #2 reset = 1'b1;
        #1;
        check("reset tx", tx_e, 1'b1);
        check("reset ocupado", ocupado_e, 1'b0);
        check("reset pronto", pronto_e, 1'b0);
        @(negedge clock); reset = 1'b0;
        hi_cnt = 0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clock); #1;
            if (tx_e === 1'b1 && ocupado_e === 1'b0) hi_cnt++;
        end
        check("idle hold", hi_cnt, 20);

        run_transfer("basic", 1'b0, bytes_a, 0);
        run_transfer("snapshot", 1'b0, bytes_a, 1);
        load_inputs(bytes_a);
        run_transfer("busy", 1'b0, bytes_a, 2);

        sel_odd = 1'b0;
        @(negedge clock);
        load_inputs(bytes_a);
        enviar_e = 1'b1;
        @(posedge clock); #1;
        enviar_e = 1'b0;
        repeat (61) @(posedge clock);
        #2 reset = 1'b1;
        #1;
        check("midreset tx", tx_e, 1'b1);
        check("midreset ocupado", ocupado_e, 1'b0);
        @(negedge clock); reset = 1'b0;
        pulses = 0;
        hi_cnt = 0;
        for (int n = 0; n < NCYC; n++) begin
            @(posedge clock); #1;
            if (pronto_e) pulses++;
            if (tx_e === 1'b1) hi_cnt++;
        end
        check("midreset no_pronto", pulses, 0);
        check("midreset idle", hi_cnt, NCYC);
        run_transfer("after_reset", 1'b0, bytes_a, 0);

        run_transfer("odd", 1'b1, bytes_b, 0);

        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < 5; i++) rb[i] = 8'($urandom);
            run_transfer($sformatf("rand%0d", t), 1'($urandom_range(0, 1)), rb, int'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
